// File: rtl/comparador_seq_if.sv
// comparador_seq_if: start/done request bus carrying the operands and the three-way result.
// Ports: master drives start, A, B (SGN); slave drives busy, done, Eo, Go, Lo.
// SGN exists only when COMPARADOR_SEQ_SIGNED_EN is defined.
interface comparador_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef COMPARADOR_SEQ_SIGNED_EN
  logic             SGN;
`endif
  logic             busy;
  logic             done;
  logic             Eo;
  logic             Go;
  logic             Lo;
`ifdef COMPARADOR_SEQ_SIGNED_EN
  modport master (output start, A, B, SGN, input busy, done, Eo, Go, Lo);
  modport slave  (input start, A, B, SGN, output busy, done, Eo, Go, Lo);
`else
  modport master (output start, A, B, input busy, done, Eo, Go, Lo);
  modport slave  (input start, A, B, output busy, done, Eo, Go, Lo);
`endif
endinterface

// File: rtl/comparador_seq.sv
// comparador_seq: multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock from the LSB chunk up.
// Ports: clk, rst (async active-high), bus (comparador_seq_if.slave: start, A, B, [SGN], busy, done, Eo, Go, Lo).
// Macro COMPARADOR_SEQ_SIGNED_EN adds SGN for two's-complement compares.
module comparador_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  comparador_seq_if.slave bus
);
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_size
    $error("comparador_seq: WIDTH must be a positive multiple of CHUNK");
  end
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             e, g, done, eo, go, lo;
  logic             last, gt, lt, e_n, g_n;
  logic [CHUNK-1:0] flip, ca, cb;
  int               base;
`ifdef COMPARADOR_SEQ_SIGNED_EN
  logic             sgn_r;
  // Flipping both sign bits in the top chunk maps two's-complement order onto unsigned order.
  assign flip = (sgn_r && last) ? MSB : '0;
`else
  assign flip = '0;
`endif
  always_comb begin
    last = cnt == CW'(NCH - 1);
    base = int'(cnt) * CHUNK;
    ca = a_r[base +: CHUNK] ^ flip;
    cb = b_r[base +: CHUNK] ^ flip;
    gt = ca > cb;
    lt = ca < cb;
    e_n = (gt || lt) ? 1'b0 : e;
    g_n = gt ? 1'b1 : lt ? 1'b0 : g;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
`ifdef COMPARADOR_SEQ_SIGNED_EN
      sgn_r <= 1'b0;
`endif
      e <= 1'b0;
      g <= 1'b0;
      done <= 1'b0;
      eo <= 1'b0;
      go <= 1'b0;
      lo <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state <= RUN;
          cnt <= '0;
          a_r <= bus.A;
          b_r <= bus.B;
`ifdef COMPARADOR_SEQ_SIGNED_EN
          sgn_r <= bus.SGN;
`endif
          e <= 1'b1;
          g <= 1'b0;
        end
      end else begin
        e <= e_n;
        g <= g_n;
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) begin
          state <= IDLE;
          done <= 1'b1;
          eo <= e_n;
          go <= g_n;
          lo <= ~e_n & ~g_n;
        end
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = done;
  assign bus.Eo = eo;
  assign bus.Go = go;
  assign bus.Lo = lo;
endmodule

// File: tb/tb_comparador_seq.sv
// tb_comparador_seq: directed vectors for comparador_seq at 16/4, 16/16 and 8/1 sizes.
module tb_comparador_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  comparador_seq_if #(.WIDTH(16)) i0 ();
  comparador_seq_if #(.WIDTH(16)) i1 ();
  comparador_seq_if #(.WIDTH(8))  i2 ();
  comparador_seq #(.WIDTH(16), .CHUNK(4))  d0 (.clk(clk), .rst(rst), .bus(i0));
  comparador_seq #(.WIDTH(16), .CHUNK(16)) d1 (.clk(clk), .rst(rst), .bus(i1));
  comparador_seq #(.WIDTH(8),  .CHUNK(1))  d2 (.clk(clk), .rst(rst), .bus(i2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] st(input int sel);
    case (sel)
      0: return {i0.busy, i0.done, i0.Eo, i0.Go, i0.Lo};
      1: return {i1.busy, i1.done, i1.Eo, i1.Go, i1.Lo};
      default: return {i2.busy, i2.done, i2.Eo, i2.Go, i2.Lo};
    endcase
  endfunction
  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s, input logic go);
    case (sel)
      0: begin i0.A = a; i0.B = b; i0.start = go; end
      1: begin i1.A = a; i1.B = b; i1.start = go; end
      default: begin i2.A = a[7:0]; i2.B = b[7:0]; i2.start = go; end
    endcase
`ifdef COMPARADOR_SEQ_SIGNED_EN
    i0.SGN = s; i1.SGN = 1'b0; i2.SGN = 1'b0;
`else
    if (s) $display("note: SGN requested without signed build");
`endif
  endtask
  task automatic launch(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    drive(sel, a, b, s, 1'b1);
    @(posedge clk);
    #1 drive(sel, a, b, s, 1'b0);
  endtask
  task automatic wait_done(input int sel, output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (lat < 40) begin
      bc += int'(st(sel)[4]);
      @(posedge clk);
      #1 lat++;
      if (st(sel)[3]) break;
    end
  endtask
  task automatic cmp(input string tag, input int sel, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input int nch, input logic [2:0] flags);
    logic [2:0] prior;
    int lat, bc;
    prior = st(sel)[2:0];
    launch(sel, a, b, s);
    chk({tag, "_hold"}, 32'(st(sel)[2:0]), 32'(prior));
    wait_done(sel, lat, bc);
    chk({tag, "_lat"}, 32'(lat), 32'(nch));
    chk({tag, "_busycyc"}, 32'(bc), 32'(nch));
    chk({tag, "_flags"}, 32'(st(sel)[2:0]), 32'(flags));
    chk({tag, "_busy_at_done"}, 32'(st(sel)[4]), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, 32'(st(sel)[3]), 32'd0);
  endtask
  initial begin
    int lat, bc, nd;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(2, 16'h0, 16'h0, 1'b0, 1'b0);
    #1 chk("reset_d0", 32'(st(0)), 32'd0);
    chk("reset_d1", 32'(st(1)), 32'd0);
    chk("reset_d2", 32'(st(2)), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    cmp("eq", 0, 16'h1234, 16'h1234, 1'b0, 4, 3'b100);
    cmp("msb_lt", 0, 16'h1235, 16'h2234, 1'b0, 4, 3'b001);
    cmp("msb_gt", 0, 16'h2233, 16'h1234, 1'b0, 4, 3'b010);
    cmp("u_8000", 0, 16'h8000, 16'h7FFF, 1'b0, 4, 3'b010);
    cmp("zero_max", 0, 16'h0000, 16'hFFFF, 1'b0, 4, 3'b001);
`ifdef COMPARADOR_SEQ_SIGNED_EN
    cmp("s_8000", 0, 16'h8000, 16'h7FFF, 1'b1, 4, 3'b001);
    cmp("s_ffff", 0, 16'hFFFF, 16'hFFFE, 1'b1, 4, 3'b010);
    cmp("s_neg_pos", 0, 16'hFFFF, 16'h0001, 1'b1, 4, 3'b001);
`endif
    launch(0, 16'h1234, 16'h1234, 1'b0);
    wait_done(0, lat, bc);
    chk("b2b_first_lat", 32'(lat), 32'd4);
    chk("b2b_first_flags", 32'(st(0)[2:0]), 32'b100);
    drive(0, 16'h2233, 16'h1234, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(0, 16'h2233, 16'h1234, 1'b0, 1'b0);
    chk("b2b_accept_busy", 32'(st(0)[4]), 32'd1);
    wait_done(0, lat, bc);
    chk("b2b_second_lat", 32'(lat), 32'd4);
    chk("b2b_second_flags", 32'(st(0)[2:0]), 32'b010);
    launch(0, 16'h1235, 16'h2234, 1'b0);
    @(posedge clk);
    #1 drive(0, 16'h2233, 16'h1234, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(0, 16'h2233, 16'h1234, 1'b0, 1'b0);
    wait_done(0, lat, bc);
    chk("ignore_lat", 32'(lat), 32'd2);
    chk("ignore_flags", 32'(st(0)[2:0]), 32'b001);
    nd = 0;
    repeat (8) begin
      @(posedge clk);
      #1 nd += int'(st(0)[3]);
    end
    chk("ignore_no_rerun", 32'(nd), 32'd0);
    launch(0, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_run", 32'(st(0)), 32'd0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(posedge clk);
      #1 nd += int'(st(0)[3]);
    end
    chk("rst_no_done", 32'(nd), 32'd0);
    cmp("after_rst", 0, 16'h00A0, 16'h00A1, 1'b0, 4, 3'b001);
    cmp("c16_lt", 1, 16'd5, 16'd9, 1'b0, 1, 3'b001);
    cmp("c16_gt", 1, 16'hF000, 16'h0FFF, 1'b0, 1, 3'b010);
    cmp("w8c1_gt", 2, 16'h0080, 16'h007F, 1'b0, 8, 3'b010);
    cmp("w8c1_eq", 2, 16'h005A, 16'h005A, 1'b0, 8, 3'b100);
    cmp("w8c1_lt", 2, 16'h0001, 16'h0002, 1'b0, 8, 3'b001);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
